// File: rtl/alu_unit_q_pkg.sv
// Shared opcode encoding and default widths for the queued integer ALU.
// Code 0 means "no operation"; any other code not listed here is treated as unknown.
package alu_unit_q_pkg;

  localparam int OP_W_DEF  = 6;
  localparam int ROB_W_DEF = 4;

  localparam logic [5:0] OP_NONE  = 6'd0;
  localparam logic [5:0] OP_LUI   = 6'd1;
  localparam logic [5:0] OP_AUIPC = 6'd2;
  localparam logic [5:0] OP_JAL   = 6'd3;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_BNE   = 6'd5;
  localparam logic [5:0] OP_BLT   = 6'd6;
  localparam logic [5:0] OP_BGE   = 6'd7;
  localparam logic [5:0] OP_BLTU  = 6'd8;
  localparam logic [5:0] OP_BGEU  = 6'd9;
  localparam logic [5:0] OP_ADDI  = 6'd10;
  localparam logic [5:0] OP_SLTI  = 6'd11;
  localparam logic [5:0] OP_SLTIU = 6'd12;
  localparam logic [5:0] OP_XORI  = 6'd13;
  localparam logic [5:0] OP_ORI   = 6'd14;
  localparam logic [5:0] OP_ANDI  = 6'd15;
  localparam logic [5:0] OP_SLLI  = 6'd16;
  localparam logic [5:0] OP_SRLI  = 6'd17;
  localparam logic [5:0] OP_SRAI  = 6'd18;
  localparam logic [5:0] OP_ADD   = 6'd19;
  localparam logic [5:0] OP_SUB   = 6'd20;
  localparam logic [5:0] OP_SLL   = 6'd21;
  localparam logic [5:0] OP_SLT   = 6'd22;
  localparam logic [5:0] OP_SLTU  = 6'd23;
  localparam logic [5:0] OP_XOR   = 6'd24;
  localparam logic [5:0] OP_SRL   = 6'd25;
  localparam logic [5:0] OP_SRA   = 6'd26;
  localparam logic [5:0] OP_OR    = 6'd27;
  localparam logic [5:0] OP_AND   = 6'd28;

endpackage

// File: rtl/alu_unit_q_core.sv
// Purely combinational integer datapath; all arithmetic wraps modulo 2^XLEN.
// Compare and branch ops produce 0/1 in bit 0; unknown opcodes produce 0.
module alu_core
  import alu_unit_q_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int OP_W = OP_W_DEF
) (
  input  logic [OP_W-1:0] i_op,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  output logic [XLEN-1:0] o_result
);

  localparam int SH_W = $clog2(XLEN);

  logic [SH_W-1:0] w_shamt;
  logic            w_eq;
  logic            w_lt;
  logic            w_ltu;

  assign w_shamt = i_rs2[SH_W-1:0];
  assign w_eq    = (i_rs1 == i_rs2);
  assign w_lt    = ($signed(i_rs1) < $signed(i_rs2));
  assign w_ltu   = (i_rs1 < i_rs2);

  always_comb begin
    o_result = '0;
    case (i_op)
      OP_W'(OP_LUI):                                o_result = i_rs1;
      OP_W'(OP_AUIPC), OP_W'(OP_ADD), OP_W'(OP_ADDI): o_result = i_rs1 + i_rs2;
      OP_W'(OP_JAL):                                o_result = i_rs2 + XLEN'(4);
      OP_W'(OP_SUB):                                o_result = i_rs1 - i_rs2;
      OP_W'(OP_BEQ):                                o_result = XLEN'(w_eq);
      OP_W'(OP_BNE):                                o_result = XLEN'(!w_eq);
      OP_W'(OP_BLT), OP_W'(OP_SLT), OP_W'(OP_SLTI):   o_result = XLEN'(w_lt);
      OP_W'(OP_BGE):                                o_result = XLEN'(!w_lt);
      OP_W'(OP_BLTU), OP_W'(OP_SLTU), OP_W'(OP_SLTIU): o_result = XLEN'(w_ltu);
      OP_W'(OP_BGEU):                               o_result = XLEN'(!w_ltu);
      OP_W'(OP_AND), OP_W'(OP_ANDI):                o_result = i_rs1 & i_rs2;
      OP_W'(OP_OR), OP_W'(OP_ORI):                  o_result = i_rs1 | i_rs2;
      OP_W'(OP_XOR), OP_W'(OP_XORI):                o_result = i_rs1 ^ i_rs2;
      OP_W'(OP_SLL), OP_W'(OP_SLLI):                o_result = i_rs1 << w_shamt;
      OP_W'(OP_SRL), OP_W'(OP_SRLI):                o_result = i_rs1 >> w_shamt;
      OP_W'(OP_SRA), OP_W'(OP_SRAI):                o_result = $signed(i_rs1) >>> w_shamt;
      default:                                      o_result = '0;
    endcase
  end

endmodule

// File: rtl/alu_unit_q.sv
// Registered ALU: computes accepted ops and buffers them in an in-order result
// queue whose head waits for a CDB grant; supports flush and global pause.
module alu_unit_q
  import alu_unit_q_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int ROB_W = ROB_W_DEF,
  parameter int OP_W  = OP_W_DEF,
  parameter int DEPTH = 4
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       rdy_in,
  input  logic                       clear_in,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [OP_W-1:0]            in_op,
  input  logic [XLEN-1:0]            in_rs1,
  input  logic [XLEN-1:0]            in_rs2,
  input  logic [ROB_W-1:0]           in_robid,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_result,
  output logic [ROB_W-1:0]           out_robid,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [XLEN-1:0]  r_resultMem [DEPTH];
  logic [ROB_W-1:0] r_robidMem  [DEPTH];
  logic [PTR_W-1:0] r_headPtr;
  logic [PTR_W-1:0] r_tailPtr;
  logic [CNT_W-1:0] r_count;

  logic [XLEN-1:0]  w_aluResult;
  logic             w_pop;
  logic             w_accept;

  alu_core #(
    .XLEN (XLEN),
    .OP_W (OP_W)
  ) u_core (
    .i_op     (in_op),
    .i_rs1    (in_rs1),
    .i_rs2    (in_rs2),
    .o_result (w_aluResult)
  );

  // A pop frees the head slot this cycle, so a full queue can still accept.
  assign out_valid  = (r_count != '0);
  assign w_pop      = out_valid && out_ready && rdy_in;
  assign in_ready   = rdy_in && !clear_in && !rst_in && ((r_count < CNT_FULL) || w_pop);
  assign w_accept   = in_valid && in_ready && (in_op != '0);
  assign out_result = out_valid ? r_resultMem[r_headPtr] : '0;
  assign out_robid  = out_valid ? r_robidMem[r_headPtr] : '0;
  assign count      = r_count;

  always_ff @(posedge clk_in) begin
    if (w_accept) begin
      r_resultMem[r_tailPtr] <= w_aluResult;
      r_robidMem[r_tailPtr]  <= in_robid;
    end
  end

  // Flush only takes effect while the pipeline is not paused.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_headPtr <= '0;
      r_tailPtr <= '0;
      r_count   <= '0;
    end else if (rdy_in) begin
      if (clear_in) begin
        r_headPtr <= '0;
        r_tailPtr <= '0;
        r_count   <= '0;
      end else begin
        if (w_accept) r_tailPtr <= r_tailPtr + PTR_ONE;
        if (w_pop)    r_headPtr <= r_headPtr + PTR_ONE;
        if (w_accept && !w_pop)      r_count <= r_count + CNT_ONE;
        else if (!w_accept && w_pop) r_count <= r_count - CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_alu_unit_q.sv
// Bench for alu_unit_q: directed scenarios then random traffic, all checked
// against a queue-based reference model; a second 64-bit instance covers wide shifts.
module tb_alu_unit_q;
  import alu_unit_q_pkg::*;

  localparam int XLEN  = 32;
  localparam int ROB_W = 4;
  localparam int OP_W  = 6;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, rdy, clr, inValid, outReady;
  logic [OP_W-1:0]  inOp;
  logic [XLEN-1:0]  rs1, rs2;
  logic [ROB_W-1:0] robid;
  logic             inReady, outValid;
  logic [XLEN-1:0]  outResult;
  logic [ROB_W-1:0] outRobid;
  logic [2:0]       count;

  logic             rst64, inValid64, inReady64, outValid64;
  logic [OP_W-1:0]  inOp64;
  logic [63:0]      rs1x64, rs2x64, outResult64;
  logic [ROB_W-1:0] robid64, outRobid64;
  logic [2:0]       count64;

  int checks = 0;
  int errors = 0;

  logic [XLEN-1:0]  qRes[$];
  logic [ROB_W-1:0] qRob[$];

  logic [5:0] opList [29] = '{OP_LUI, OP_AUIPC, OP_JAL, OP_BEQ, OP_BNE, OP_BLT, OP_BGE,
                              OP_BLTU, OP_BGEU, OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI,
                              OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI, OP_ADD, OP_SUB, OP_SLL,
                              OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND, 6'd45};

  alu_unit_q #(.XLEN(XLEN), .ROB_W(ROB_W), .OP_W(OP_W), .DEPTH(DEPTH)) dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .clear_in(clr),
    .in_valid(inValid), .in_ready(inReady), .in_op(inOp), .in_rs1(rs1), .in_rs2(rs2),
    .in_robid(robid), .out_valid(outValid), .out_ready(outReady), .out_result(outResult),
    .out_robid(outRobid), .count(count)
  );

  alu_unit_q #(.XLEN(64), .ROB_W(ROB_W), .OP_W(OP_W), .DEPTH(DEPTH)) dut64 (
    .clk_in(clk), .rst_in(rst64), .rdy_in(1'b1), .clear_in(1'b0),
    .in_valid(inValid64), .in_ready(inReady64), .in_op(inOp64), .in_rs1(rs1x64), .in_rs2(rs2x64),
    .in_robid(robid64), .out_valid(outValid64), .out_ready(1'b0), .out_result(outResult64),
    .out_robid(outRobid64), .count(count64)
  );

  // Reference arithmetic written from the instruction semantics.
  function automatic logic [31:0] refAlu(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
    int unsigned sh;
    logic [31:0] fill;
    sh = int'(b[4:0]);
    fill = a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0;
    case (op)
      OP_LUI:                     return a;
      OP_AUIPC, OP_ADD, OP_ADDI:  return a + b;
      OP_JAL:                     return b + 32'd4;
      OP_SUB:                     return a - b;
      OP_BEQ:                     return (a == b) ? 32'd1 : 32'd0;
      OP_BNE:                     return (a != b) ? 32'd1 : 32'd0;
      OP_BLT, OP_SLT, OP_SLTI:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_BGE:                     return ($signed(a) >= $signed(b)) ? 32'd1 : 32'd0;
      OP_BLTU, OP_SLTU, OP_SLTIU: return (a < b) ? 32'd1 : 32'd0;
      OP_BGEU:                    return (a >= b) ? 32'd1 : 32'd0;
      OP_AND, OP_ANDI:            return a & b;
      OP_OR, OP_ORI:              return a | b;
      OP_XOR, OP_XORI:            return a ^ b;
      OP_SLL, OP_SLLI:            return a << sh;
      OP_SRL, OP_SRLI:            return a >> sh;
      OP_SRA, OP_SRAI:            return (a >> sh) | fill;
      default:                    return 32'd0;
    endcase
  endfunction

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    int   sz = qRes.size();
    logic expPop = (sz > 0) && outReady && rdy;
    logic expReady = rdy && !clr && !rst && ((sz < DEPTH) || expPop);
    checkVal("in_ready", 64'(inReady), 64'(expReady));
    checkVal("out_valid", 64'(outValid), 64'(sz > 0));
    checkVal("out_result", 64'(outResult), (sz > 0) ? 64'(qRes[0]) : 64'd0);
    checkVal("out_robid", 64'(outRobid), (sz > 0) ? 64'(qRob[0]) : 64'd0);
    checkVal("count", 64'(count), 64'(sz));
  endtask

  task automatic modelUpdate();
    int   sz = qRes.size();
    logic pop = (sz > 0) && outReady && rdy;
    logic acc = inValid && (inOp != '0) && rdy && !clr && !rst && ((sz < DEPTH) || pop);
    if (rst || (rdy && clr)) begin
      qRes.delete();
      qRob.delete();
    end else if (rdy) begin
      if (pop) begin
        void'(qRes.pop_front());
        void'(qRob.pop_front());
      end
      if (acc) begin
        qRes.push_back(refAlu(inOp, rs1, rs2));
        qRob.push_back(robid);
      end
    end
  endtask

  task automatic applyStimulus(input logic tRst, input logic tRdy, input logic tClr, input logic tValid,
                               input logic [5:0] tOp, input logic [31:0] tA, input logic [31:0] tB,
                               input logic [3:0] tId, input logic tOutReady);
    rst = tRst; rdy = tRdy; clr = tClr; inValid = tValid;
    inOp = tOp; rs1 = tA; rs2 = tB; robid = tId; outReady = tOutReady;
  endtask

  task automatic tick();
    @(negedge clk);
    checkOutput();
    modelUpdate();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] expShift [4] = '{32'hC000_0000, 32'h4000_0000, 32'h0, 32'h1};

  initial begin
    rst64 = 1'b1; inValid64 = 1'b0; inOp64 = '0; rs1x64 = '0; rs2x64 = '0; robid64 = '0;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 32'd0, 32'd0, 4'd0, 1'b0);
    @(posedge clk);
    #1;
    tick();
    rst64 = 1'b0;
    checkVal("rst_count", 64'(count), 64'd0);

    // Single add with immediate grant
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, OP_ADD, 32'd5, 32'd7, 4'd3, 1'b1);
    tick();
    checkVal("add_valid", 64'(outValid), 64'd1);
    checkVal("add_result", 64'(outResult), 64'd12);
    checkVal("add_robid", 64'(outRobid), 64'd3);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 32'd0, 32'd0, 4'd0, 1'b1);
    tick();
    checkVal("add_popCount", 64'(count), 64'd0);

    // Fill, then pop-through while full
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, OP_ADDI, 32'd0, 32'(i), 4'(i), 1'b0);
      tick();
    end
    checkVal("full_count", 64'(count), 64'd4);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, OP_ADDI, 32'd0, 32'd5, 4'd5, 1'b0);
    #1;
    checkVal("full_inReady", 64'(inReady), 64'd0);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, OP_ADDI, 32'd0, 32'd5, 4'd5, 1'b1);
    #1;
    checkVal("popThrough_inReady", 64'(inReady), 64'd1);
    tick();
    checkVal("popThrough_count", 64'(count), 64'd4);
    for (int k = 2; k <= 5; k++) begin
      checkVal("fifo_order", 64'(outResult), 64'(k));
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 32'd0, 32'd0, 4'd0, 1'b1);
      tick();
    end

    // Shift and compare corner values
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, OP_SRA, 32'h8000_0000, 32'h21, 4'd1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, OP_SRL, 32'h8000_0000, 32'h21, 4'd2, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, OP_SLTU, 32'hFFFF_FFFF, 32'd1, 4'd3, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, OP_SLT, 32'hFFFF_FFFF, 32'd1, 4'd4, 1'b0);
    tick();
    for (int k = 0; k < 4; k++) begin
      checkVal("shiftCmp_result", 64'(outResult), 64'(expShift[k]));
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 32'd0, 32'd0, 4'd0, 1'b1);
      tick();
    end

    // Flush with a same-cycle offered op
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, OP_ADD, 32'(i), 32'd1, 4'(i), 1'b0);
      tick();
    end
    checkVal("preClear_count", 64'(count), 64'd3);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, OP_ADD, 32'd100, 32'd1, 4'd9, 1'b1);
    tick();
    checkVal("clear_count", 64'(count), 64'd0);
    checkVal("clear_valid", 64'(outValid), 64'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 32'd0, 32'd0, 4'd0, 1'b1);
    tick();
    checkVal("clear_stillEmpty", 64'(outValid), 64'd0);

    // Global pause freezes the queue; flush is ignored while paused
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, OP_ADD, 32'd10, 32'd1, 4'd6, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, OP_ADD, 32'd20, 32'd2, 4'd7, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, (i == 2), 1'b1, OP_ADD, 32'd1, 32'd1, 4'd8, 1'b1);
      tick();
      checkVal("pause_count", 64'(count), 64'd2);
      checkVal("pause_result", 64'(outResult), 64'd11);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 32'd0, 32'd0, 4'd0, 1'b1);
    tick();
    checkVal("resume_count", 64'(count), 64'd1);
    checkVal("resume_result", 64'(outResult), 64'd22);

    // Opcode 0 is dropped
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 6'd0, 32'd1, 32'd2, 4'd8, 1'b0);
    tick();
    checkVal("op0_count", 64'(count), 64'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 32'd0, 32'd0, 4'd0, 1'b1);
    tick();

    // Wide build: full-range shift amount and dropped opcode 0
    inValid64 = 1'b1; inOp64 = OP_SLL; rs1x64 = 64'd1; rs2x64 = 64'd63; robid64 = 4'd2;
    tick();
    checkVal("x64_sll", outResult64, 64'h8000_0000_0000_0000);
    inOp64 = 6'd0;
    tick();
    inValid64 = 1'b0;
    checkVal("x64_op0Count", 64'(count64), 64'd1);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a, b;
      logic [5:0]  op;
      a  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      op = ($urandom_range(0, 9) == 0) ? 6'd0 : opList[$urandom_range(0, 28)];
      applyStimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) != 0),
                    ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
                    op, a, b, 4'($urandom_range(0, 15)), ($urandom_range(0, 1) == 1));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
